signed_adder_tree: RTL and testbench



---
 rtl/dsp_pkg.sv | 52 +++++
 rtl/adder_tree_node.sv | 35 +++
 rtl/signed_adder_tree.sv | 81 ++++++++
 tb/tb_signed_adder_tree.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP helpers: width arithmetic for adder trees and a range-reduction
// (saturate or wrap) helper usable by any signed datapath up to 64 bits.
package dsp_pkg;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int fw(input int iwidth, input int ninputs);
    return iwidth + clog2(ninputs);
  endfunction

  function automatic int node_count(input int ninputs, input int level);
    return (ninputs + (1 << level) - 1) >> level;
  endfunction

  // Bit offset of a tree level inside a flat vector where level j packs
  // node_count(j) nodes of iwidth+j bits each.
  function automatic int level_base(input int iwidth, input int ninputs, input int level);
    int b = 0;
    for (int i = 0; i < level; i++) b += node_count(ninputs, i) * (iwidth + i);
    return b;
  endfunction

  // Reduce x to a signed ow-bit range; result is returned sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_wrap_value(input logic signed [63:0] x,
                                                        input int ow, input bit sat);
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    logic signed [63:0] low;
    if (ow >= 64) return x;
    maxv = (64'sd1 <<< (ow - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (ow - 1));
    low  = (x <<< (64 - ow)) >>> (64 - ow);
    if (!sat) return low;
    if (x > maxv) return maxv;
    if (x < minv) return minv;
    return x;
  endfunction

  // Set when x does not fit ow signed bits, i.e. the discarded MSBs are not
  // all copies of bit ow-1; identical for the clamp and the wrap policy.
  function automatic logic sat_wrap_flag(input logic signed [63:0] x, input int ow);
    logic signed [63:0] low;
    if (ow >= 64) return 1'b0;
    low = (x <<< (64 - ow)) >>> (64 - ow);
    return low != x;
  endfunction

endpackage

// File: rtl/adder_tree_node.sv
// One registered adder-tree node: sign-extending add of two W-bit children,
// or a sign-extending pass-through for the odd leftover child.
module adder_tree_node #(
  parameter int W    = 16,
  parameter bit PASS = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [(PASS ? W : 2*W)-1:0]  din,
  output logic [W:0]                   sum
);

  localparam int WO = W + 1;

  logic signed [W:0] nxt;

  if (PASS) begin : g_pass
    logic signed [W-1:0] a;
    assign a   = din;
    assign nxt = WO'(a);
  end else begin : g_add
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    assign a   = din[W-1:0];
    assign b   = din[2*W-1:W];
    assign nxt = WO'(a) + WO'(b);
  end

  always_ff @(posedge clk) begin
    if (reset)   sum <= '0;
    else if (en) sum <= nxt;
  end

endmodule

// File: rtl/signed_adder_tree.sv
// Pipelined NINPUTS-operand signed adder: clog2(NINPUTS) registered tree
// levels followed by a registered saturate/wrap stage, valid-qualified.
module signed_adder_tree
  import dsp_pkg::*;
#(
  parameter int IWIDTH   = 16,
  parameter int NINPUTS  = 8,
  parameter int OWIDTH   = IWIDTH + clog2(NINPUTS),
  parameter int SATURATE = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [NINPUTS*IWIDTH-1:0]   i_data,
  output logic                        o_valid,
  output logic [OWIDTH-1:0]           o_sum,
  output logic                        o_sat
);

  localparam int FW  = fw(IWIDTH, NINPUTS);
  localparam int D   = clog2(NINPUTS);
  localparam int TOT = level_base(IWIDTH, NINPUTS, D + 1);

  // All levels packed back to back; level 0 is the raw operand vector.
  logic [TOT-1:0]       tree;
  logic [D:0]           vld;
  logic signed [FW-1:0] root;

  assign tree[NINPUTS*IWIDTH-1:0] = i_data;

  for (genvar j = 1; j <= D; j++) begin : g_lvl
    localparam int W  = IWIDTH + j - 1;
    localparam int NC = node_count(NINPUTS, j - 1);
    localparam int NP = node_count(NINPUTS, j);
    localparam int IB = level_base(IWIDTH, NINPUTS, j - 1);
    localparam int OB = level_base(IWIDTH, NINPUTS, j);

    logic en;
    if (j == 1) begin : g_first
      assign en = i_valid;
    end else begin : g_rest
      assign en = vld[j-2];
    end

    // ---- tree level j: registered, loads only on its incoming valid ----
    for (genvar k = 0; k < NP; k++) begin : g_node
      localparam bit PASS = (2*k + 1 >= NC);
      localparam int IN_W = PASS ? W : 2*W;
      adder_tree_node #(
        .W    (W),
        .PASS (PASS)
      ) u_node (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (en),
        .din   (tree[IB + 2*k*W +: IN_W]),
        .sum   (tree[OB + k*(W+1) +: W+1])
      );
    end
  end

  assign root = tree[TOT-1 -: FW];

  // ---- final stage: range reduction to OWIDTH and valid chain ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld   <= '0;
      o_sum <= '0;
      o_sat <= 1'b0;
    end else begin
      vld <= {vld[D-1:0], i_valid};
      if (vld[D-1]) begin
        o_sum <= OWIDTH'(sat_wrap_value(64'(root), OWIDTH, SATURATE != 0));
        o_sat <= sat_wrap_flag(64'(root), OWIDTH);
      end
    end
  end

  assign o_valid = vld[D];

endmodule

// File: tb/tb_signed_adder_tree.sv
// Scoreboard bench for signed_adder_tree across five configurations sharing
// one clock and one reset.
module tb_signed_adder_tree;

  typedef struct {
    int   sum;
    logic sat;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic         rst;
  logic         abc_iv;
  logic [31:0]  abc_data;
  logic         d_iv;
  logic [23:0]  d_data;
  logic         e_iv;
  logic [127:0] e_data;

  logic               a_valid, b_valid, c_valid, d_valid, e_valid;
  logic signed [9:0]  a_sum;
  logic signed [7:0]  b_sum;
  logic signed [7:0]  c_sum;
  logic signed [9:0]  d_sum;
  logic signed [18:0] e_sum;
  logic               a_sat, b_sat, c_sat, d_sat, e_sat;
  logic signed [18:0] e_last;

  exp_t qa[$], qb[$], qc[$], qd[$], qe[$];

  // A: 4x8 full width; B: 4x8 -> 8 clamp; C: 4x8 -> 8 wrap; D: 3x8; E: 8x16 defaults
  signed_adder_tree #(.IWIDTH(8), .NINPUTS(4)) u_a (
    .i_clk(clk), .i_reset(rst), .i_valid(abc_iv), .i_data(abc_data),
    .o_valid(a_valid), .o_sum(a_sum), .o_sat(a_sat));
  signed_adder_tree #(.IWIDTH(8), .NINPUTS(4), .OWIDTH(8), .SATURATE(1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_valid(abc_iv), .i_data(abc_data),
    .o_valid(b_valid), .o_sum(b_sum), .o_sat(b_sat));
  signed_adder_tree #(.IWIDTH(8), .NINPUTS(4), .OWIDTH(8), .SATURATE(0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_valid(abc_iv), .i_data(abc_data),
    .o_valid(c_valid), .o_sum(c_sum), .o_sat(c_sat));
  signed_adder_tree #(.IWIDTH(8), .NINPUTS(3)) u_d (
    .i_clk(clk), .i_reset(rst), .i_valid(d_iv), .i_data(d_data),
    .o_valid(d_valid), .o_sum(d_sum), .o_sat(d_sat));
  signed_adder_tree u_e (
    .i_clk(clk), .i_reset(rst), .i_valid(e_iv), .i_data(e_data),
    .o_valid(e_valid), .o_sum(e_sum), .o_sat(e_sat));

  // Reference range reduction of an exact integer sum.
  function automatic void ref_out(input int s, input int ow, input bit sat,
                                  output int v, output logic f);
    int lim, w;
    lim = 1 << (ow - 1);
    f   = (s >= lim) || (s < -lim);
    if (!f) v = s;
    else if (sat) v = (s >= lim) ? lim - 1 : -lim;
    else begin
      w = s & ((1 << ow) - 1);
      v = (w >= lim) ? w - (1 << ow) : w;
    end
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_abc(input int o0, input int o1, input int o2, input int o3, input bit v);
    exp_t e;
    int   s, val;
    logic f;
    abc_iv   = v;
    abc_data = {8'(o3), 8'(o2), 8'(o1), 8'(o0)};
    if (v) begin
      s     = o0 + o1 + o2 + o3;
      e.due = cyc + 3;
      ref_out(s, 10, 1'b0, val, f); e.sum = val; e.sat = f; qa.push_back(e);
      ref_out(s, 8, 1'b1, val, f);  e.sum = val; e.sat = f; qb.push_back(e);
      ref_out(s, 8, 1'b0, val, f);  e.sum = val; e.sat = f; qc.push_back(e);
    end
  endtask

  task automatic drive_d(input int o0, input int o1, input int o2, input bit v);
    exp_t e;
    int   val;
    logic f;
    d_iv   = v;
    d_data = {8'(o2), 8'(o1), 8'(o0)};
    if (v) begin
      e.due = cyc + 3;
      ref_out(o0 + o1 + o2, 10, 1'b0, val, f);
      e.sum = val; e.sat = f;
      qd.push_back(e);
    end
  endtask

  task automatic drive_e(input logic [127:0] data, input bit v);
    exp_t e;
    int   s, val;
    logic f;
    e_iv   = v;
    e_data = data;
    if (v) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += int'($signed(data[k*16 +: 16]));
      e.due = cyc + 4;
      ref_out(s, 19, 1'b0, val, f);
      e.sum = val; e.sat = f;
      qe.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    abc_iv   = 1'b1; abc_data = 32'h7f80_7f80;
    d_iv     = 1'b1; d_data   = 24'h7f7f7f;
    e_iv     = 1'b1; e_data   = {8{16'h7fff}};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({a_valid, a_sum, a_sat} !== '0) begin
        n_bad++; $display("FAIL reset_a: got %0h, required 0", {a_valid, a_sum, a_sat});
      end
      n_cmp++;
      if ({b_valid, b_sum, b_sat} !== '0) begin
        n_bad++; $display("FAIL reset_b: got %0h, required 0", {b_valid, b_sum, b_sat});
      end
      n_cmp++;
      if ({c_valid, c_sum, c_sat} !== '0) begin
        n_bad++; $display("FAIL reset_c: got %0h, required 0", {c_valid, c_sum, c_sat});
      end
      n_cmp++;
      if ({d_valid, d_sum, d_sat} !== '0) begin
        n_bad++; $display("FAIL reset_d: got %0h, required 0", {d_valid, d_sum, d_sat});
      end
      n_cmp++;
      if ({e_valid, e_sum, e_sat} !== '0) begin
        n_bad++; $display("FAIL reset_e: got %0h, required 0", {e_valid, e_sum, e_sat});
      end
    end
    rst = 1'b0; abc_iv = 1'b0; d_iv = 1'b0; e_iv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({a_valid, b_valid, c_valid, d_valid, e_valid} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_ignored_valid: o_valid a..e=%b, required 00000",
                 {a_valid, b_valid, c_valid, d_valid, e_valid});
      end
    end
  endtask

  task automatic test_single_beat();
    exp_t ex;
    drive_abc(10, -15, 3, -2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      drive_abc(0, 0, 0, 0, 1'b0);
      if (a_valid) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_bad++; $display("FAIL single_extra: o_sum=%0d at cycle %0d, required no output", a_sum, cyc);
        end else begin
          ex = qa.pop_front();
          if (int'(a_sum) !== ex.sum || a_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL single_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     a_sum, a_sat, cyc, ex.sum, ex.sat, ex.due);
          end
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL single_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qa[0].sum);
        void'(qa.pop_front());
      end
    end
    qb.delete(); qc.delete();
  endtask

  task automatic test_extremes();
    exp_t ex;
    int   tbl [4][4];
    tbl = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128},
            '{100, -100, 5, -6},   '{-128, 127, -128, 127}};
    for (int i = 0; i < 20; i++) begin
      if (i < 4)       drive_abc(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 1'b1);
      else if (i == 4) drive_abc(0, 0, 0, 0, 1'b0);
      else if (i < 10) drive_abc(rnd8(), rnd8(), rnd8(), rnd8(), 1'b1);
      else             drive_abc(0, 0, 0, 0, 1'b0);
      tick();
      if (a_valid) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_bad++; $display("FAIL full_extra: o_sum=%0d at cycle %0d, required no output", a_sum, cyc);
        end else begin
          ex = qa.pop_front();
          if (int'(a_sum) !== ex.sum || a_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL full_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     a_sum, a_sat, cyc, ex.sum, ex.sat, ex.due);
          end
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL full_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qa[0].sum);
        void'(qa.pop_front());
      end
      if (b_valid) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_bad++; $display("FAIL clamp_extra: o_sum=%0d at cycle %0d, required no output", b_sum, cyc);
        end else begin
          ex = qb.pop_front();
          if (int'(b_sum) !== ex.sum || b_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL clamp_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     b_sum, b_sat, cyc, ex.sum, ex.sat, ex.due);
          end
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL clamp_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qb[0].sum);
        void'(qb.pop_front());
      end
      if (c_valid) begin
        n_cmp++;
        if (qc.size() == 0) begin
          n_bad++; $display("FAIL wrap_extra: o_sum=%0d at cycle %0d, required no output", c_sum, cyc);
        end else begin
          ex = qc.pop_front();
          if (int'(c_sum) !== ex.sum || c_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL wrap_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     c_sum, c_sat, cyc, ex.sum, ex.sat, ex.due);
          end
        end
      end else if (qc.size() != 0 && qc[0].due <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL wrap_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qc[0].sum);
        void'(qc.pop_front());
      end
    end
  endtask

  task automatic test_odd_inputs();
    exp_t ex;
    int   tbl [4][3];
    tbl = '{'{-128, -128, -128}, '{1, 2, 3}, '{127, 127, 127}, '{-1, 0, 1}};
    for (int i = 0; i < 18; i++) begin
      if (i < 4)       drive_d(tbl[i][0], tbl[i][1], tbl[i][2], 1'b1);
      else if (i < 10) drive_d(rnd8(), rnd8(), rnd8(), (i % 3) != 1);
      else             drive_d(0, 0, 0, 1'b0);
      tick();
      if (d_valid) begin
        n_cmp++;
        if (qd.size() == 0) begin
          n_bad++; $display("FAIL odd_extra: o_sum=%0d at cycle %0d, required no output", d_sum, cyc);
        end else begin
          ex = qd.pop_front();
          if (int'(d_sum) !== ex.sum || d_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL odd_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     d_sum, d_sat, cyc, ex.sum, ex.sat, ex.due);
          end
        end
      end else if (qd.size() != 0 && qd[0].due <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL odd_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qd[0].sum);
        void'(qd.pop_front());
      end
    end
  endtask

  task automatic test_stream_gaps();
    exp_t         ex;
    logic [127:0] data;
    int           nbeat = 0;
    e_last = '0;
    for (int i = 0; i < 170; i++) begin
      if (i < 160 && $urandom_range(0, 9) < 6) begin
        nbeat++;
        data = {$urandom, $urandom, $urandom, $urandom};
        if (nbeat % 23 == 0) data = {8{16'h8000}};
        if (nbeat % 29 == 0) data = {8{16'h7fff}};
        drive_e(data, 1'b1);
      end else begin
        drive_e({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      end
      tick();
      if (e_valid) begin
        n_cmp++;
        if (qe.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: o_sum=%0d at cycle %0d, required no output", e_sum, cyc);
        end else begin
          ex = qe.pop_front();
          if (int'(e_sum) !== ex.sum || e_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL stream_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     e_sum, e_sat, cyc, ex.sum, ex.sat, ex.due);
          end
          e_last = ex.sum[18:0];
        end
      end else begin
        n_cmp++;
        if (e_sum !== e_last) begin
          n_bad++; $display("FAIL stream_hold: o_sum=%0d in gap, required held %0d", e_sum, e_last);
        end
        if (qe.size() != 0 && qe[0].due <= cyc) begin
          n_bad++;
          $display("FAIL stream_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qe[0].sum);
          void'(qe.pop_front());
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t ex;
    for (int i = 0; i < 18; i++) begin
      rst = (i == 2);
      if (i < 10) drive_abc(i + 1, -(i + 2), 3 * i, 7, 1'b1);
      else        drive_abc(0, 0, 0, 0, 1'b0);
      tick();
      if (i == 2) begin
        n_cmp++;
        if ({a_valid, a_sum, a_sat} !== '0 || b_valid !== 1'b0 || c_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL midreset_clear: a=%0h b_valid=%0b c_valid=%0b, required all 0",
                   {a_valid, a_sum, a_sat}, b_valid, c_valid);
        end
        qa.delete(); qb.delete(); qc.delete();
      end else if (a_valid) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_bad++; $display("FAIL midreset_extra: o_sum=%0d at cycle %0d, required no output", a_sum, cyc);
        end else begin
          ex = qa.pop_front();
          if (int'(a_sum) !== ex.sum || a_sat !== ex.sat || cyc !== ex.due) begin
            n_bad++;
            $display("FAIL midreset_beat: sum=%0d sat=%0b cycle=%0d, required sum=%0d sat=%0b cycle=%0d",
                     a_sum, a_sat, cyc, ex.sum, ex.sat, ex.due);
          end
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL midreset_missing: o_valid=0 at cycle %0d, required sum=%0d", cyc, qa[0].sum);
        void'(qa.pop_front());
      end
    end
    qb.delete(); qc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; abc_iv = 1'b0; abc_data = '0; d_iv = 1'b0; d_data = '0;
    e_iv = 1'b0; e_data = '0; e_last = '0;
    test_reset();
    test_single_beat();
    test_extremes();
    test_odd_inputs();
    test_stream_gaps();
    test_reset_midstream();
    n_cmp++;
    if (qa.size() + qd.size() + qe.size() != 0) begin
      n_bad++;
      $display("FAIL drained: %0d beats still pending, required 0", qa.size() + qd.size() + qe.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
